corr_frame_reader: RTL and testbench
====================================

CORR_FRAME_READER -- requirements
Module: corr_frame_reader

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 32: width of each accumulated correlator word.
REQ-002 SHALL have parameter VECTOR_LEN, default 64: bins per frame; a power of two, at least 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have ports r11, r22, r12_re, r12_im, input, DIN_WIDTH each: correlator outputs; r11/r22 unsigned, r12 signed, stored as raw bits.
REQ-006 SHALL have port din_valid, input, 1 bit: the four words are valid this cycle.
REQ-007 SHALL have port din_first, input, 1 bit: qualifies the bin-0 sample of a frame; ignored unless din_valid is high.
REQ-008 SHALL have port arm, input, 1 bit: single-cycle request to capture the next frame.
REQ-009 SHALL have port continuous, input, 1 bit: when high, re-arm automatically after each readout.
REQ-010 SHALL have ports dout, output, DIN_WIDTH bits, and dout_valid, output, 1 bit: stream word and its qualifier.
REQ-011 SHALL have port dout_ready, input, 1 bit: the downstream consumer accepts a word.
REQ-012 SHALL have port dout_last, output, 1 bit: marks the final word of a frame.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have ports frame_cnt and drop_cnt, output, 16 bits each: frames fully read out, and frames missed while in READOUT.

Function
REQ-015 SHALL implement the states IDLE, ARMED, CAPTURE and READOUT.
REQ-016 SHALL go IDLE->ARMED on arm high in IDLE, or when continuous is high in IDLE.
- arm in any other state is ignored.
REQ-017 SHALL go ARMED->CAPTURE on din_valid && din_first, writing that sample as bin 0.
- In ARMED, samples without din_first are discarded.
REQ-018 SHALL, in CAPTURE, write each din_valid sample to the next bin index.
- Gaps in din_valid are allowed.
REQ-019 SHALL go CAPTURE->READOUT on the cycle after bin VECTOR_LEN-1 is written.
REQ-020 SHALL, on din_valid && din_first during CAPTURE, discard the partial frame and restart at bin 0 with the new sample.
- drop_cnt is unchanged in this case.
REQ-021 SHALL buffer 4*VECTOR_LEN words.
REQ-022 SHALL emit 4*VECTOR_LEN words per frame in READOUT, bin-major.
- Word order per bin: r11, r22, r12_re, r12_im, for bin 0 up to bin VECTOR_LEN-1.
REQ-023 SHALL make a word transfer occur only on a cycle with dout_valid && dout_ready.
REQ-024 SHALL hold dout, dout_valid and dout_last stable while dout_valid && !dout_ready.
REQ-025 SHALL assert dout_valid within 3 cycles of entering READOUT.
REQ-026 SHALL sustain one word per cycle while dout_ready is held high; no bubbles after the first word.
REQ-027 SHALL assert dout_last only with the r12_im word of bin VECTOR_LEN-1.
REQ-028 SHALL, on transfer of the last word, perform all of the following:
- increment frame_cnt;
- go to ARMED if continuous is high, else to IDLE;
- deassert dout_valid the next cycle.
REQ-029 SHALL increment drop_cnt once per din_valid && din_first seen in READOUT; such samples are not stored.
REQ-030 SHALL let frame_cnt and drop_cnt wrap from 0xFFFF to 0.
REQ-031 SHALL keep dout_valid low outside READOUT.

Reset
REQ-032 SHALL, while rst_n is low, place the FSM in IDLE with all counters and bin/word indices at 0.
REQ-033 SHALL, while rst_n is low, drive dout_valid, dout_last and busy to 0, frame_cnt and drop_cnt to 0, and dout to 0.
REQ-034 SHALL, on reset mid-CAPTURE or mid-READOUT, abandon the frame with no further output words; buffer contents need not be cleared.
REQ-035 SHALL accept the first arm on the first rising edge after rst_n deasserts.

Verification
REQ-036 SHALL be verified with the following directed scenarios (VECTOR_LEN=4 allowed):
- Basic: arm, one frame with bin k = (r11=10k+1, r22=10k+2, r12_re=-(10k+3), r12_im=10k+4), dout_ready=1 -> 16 words 1,2,-3,4,11,...,34 in order; dout_last on word 16; frame_cnt=1; returns to IDLE.
- Backpressure: same frame, dout_ready random 50% -> identical word sequence; outputs stable while stalled; exactly 16 transfers.
- Resync: din_first at bin 2 of CAPTURE -> capture restarts; output reflects only the second frame; drop_cnt=0.
- Overrun: continuous=1, dout_ready=0 for 3 input frames, then 1 -> drop_cnt=2 after the 2 frames that start in READOUT; first frame read out intact; re-arms after readout.
- Reset: rst_n low during READOUT after word 5 -> dout_valid=0, busy=0, counters 0; next arm captures a fresh frame correctly.
- Gapped input: din_valid toggling 1-0-1 during CAPTURE -> same output as the Basic scenario.

Source files
------------

// File: rtl/corr_frame_reader.sv
// -----------------------------------------------------------------------------
// corr_frame_reader
//
// Captures one frame of accumulated correlator output (VECTOR_LEN bins, four
// words per bin) into an internal buffer, then streams the buffered words out
// over a valid/ready interface, bin-major, in the order r11, r22, r12_re,
// r12_im. Frames that begin while a readout is in progress are counted as
// dropped and not stored.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   r11, r22, r12_re, r12_im    correlator words for one bin (raw bits)
//   din_valid, din_first        sample qualifier, bin-0 marker
//   arm                         one-cycle request to capture the next frame
//   continuous                  re-arm automatically after each readout
//   dout, dout_valid,
//   dout_ready, dout_last       output word stream, last marks final word
//   busy                        high in every state except IDLE
//   frame_cnt                   frames fully read out (wraps)
//   drop_cnt                    frame starts seen during readout (wraps)
// -----------------------------------------------------------------------------
module corr_frame_reader #(
    parameter int DIN_WIDTH  = 32,
    parameter int VECTOR_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] r11,
    input  logic [DIN_WIDTH-1:0] r22,
    input  logic [DIN_WIDTH-1:0] r12_re,
    input  logic [DIN_WIDTH-1:0] r12_im,
    input  logic                 din_valid,
    input  logic                 din_first,
    input  logic                 arm,
    input  logic                 continuous,
    output logic [DIN_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          drop_cnt
);

    localparam int BIN_W  = $clog2(VECTOR_LEN);
    localparam int WORD_W = BIN_W + 2;  // bin index plus 2-bit component select

    localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(VECTOR_LEN - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(4 * VECTOR_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_READOUT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // One bank per component so a whole bin is written in a single cycle.
    logic [DIN_WIDTH-1:0] r_mem_r11    [VECTOR_LEN];
    logic [DIN_WIDTH-1:0] r_mem_r22    [VECTOR_LEN];
    logic [DIN_WIDTH-1:0] r_mem_r12_re [VECTOR_LEN];
    logic [DIN_WIDTH-1:0] r_mem_r12_im [VECTOR_LEN];

    logic [BIN_W-1:0]     r_bin_idx;     // next bin to write during capture
    logic [WORD_W-1:0]    r_rd_idx;      // next word to load into the output register
    logic                 r_rd_all;      // every word of the frame has been loaded
    logic [DIN_WIDTH-1:0] r_dout;
    logic                 r_dout_valid;
    logic                 r_dout_last;
    logic [15:0]          r_frame_cnt;
    logic [15:0]          r_drop_cnt;

    logic                 w_wr_en;
    logic [BIN_W-1:0]     w_wr_bin;
    logic                 w_drop_inc;
    logic                 w_busy;
    logic                 w_load;
    logic                 w_last_xfer;
    logic [BIN_W-1:0]     w_rd_bin;
    logic [DIN_WIDTH-1:0] w_rd_word;

    // The output register refills whenever it is empty or being drained, which
    // keeps one word per cycle under continuous dout_ready.
    assign w_load      = (r_state == ST_READOUT) && !r_rd_all && (!r_dout_valid || dout_ready);
    assign w_last_xfer = r_dout_valid && dout_ready && r_dout_last;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked processes use non-blocking (<=) so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (arm || continuous) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (din_valid && din_first) w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // A din_first sample restarts at bin 0 and never completes a frame.
                if (din_valid && !din_first && (r_bin_idx == LAST_BIN))
                    w_next_state = ST_READOUT;
            end
            ST_READOUT: begin
                if (w_last_xfer) w_next_state = continuous ? ST_ARMED : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_bin   = '0;
        w_drop_inc = 1'b0;
        w_busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_ARMED: begin
                w_wr_en = din_valid && din_first;
            end
            ST_CAPTURE: begin
                w_wr_en  = din_valid;
                w_wr_bin = din_first ? '0 : r_bin_idx;
            end
            ST_READOUT: begin
                w_drop_inc = din_valid && din_first;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer has no reset; every readout is preceded by a full
    // capture, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_r11[w_wr_bin]    <= r11;
            r_mem_r22[w_wr_bin]    <= r22;
            r_mem_r12_re[w_wr_bin] <= r12_re;
            r_mem_r12_im[w_wr_bin] <= r12_im;
        end
    end

    assign w_rd_bin = r_rd_idx[WORD_W-1:2];

    always_comb begin
        w_rd_word = '0;
        case (r_rd_idx[1:0])
            2'd0:    w_rd_word = r_mem_r11[w_rd_bin];
            2'd1:    w_rd_word = r_mem_r22[w_rd_bin];
            2'd2:    w_rd_word = r_mem_r12_re[w_rd_bin];
            default: w_rd_word = r_mem_r12_im[w_rd_bin];
        endcase
    end

    // -------------------------------------------------------------------------
    // Indices, output register and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin_idx    <= '0;
            r_rd_idx     <= '0;
            r_rd_all     <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_frame_cnt  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            // Wraps to 0 after the last bin, ready for the next capture.
            if (w_wr_en) r_bin_idx <= w_wr_bin + 1'b1;

            if (w_load) begin
                r_dout       <= w_rd_word;
                r_dout_valid <= 1'b1;
                r_dout_last  <= (r_rd_idx == LAST_WORD);
                r_rd_idx     <= r_rd_idx + 1'b1;
                if (r_rd_idx == LAST_WORD) r_rd_all <= 1'b1;
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
                r_dout_last  <= 1'b0;
            end

            if (w_last_xfer) begin
                r_rd_all    <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = w_busy;
    assign frame_cnt  = r_frame_cnt;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_corr_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_corr_frame_reader
//
// Directed bench for corr_frame_reader with VECTOR_LEN=4. Bin k of a frame
// carries r11=10k+1+off, r22=10k+2+off, r12_re=-(10k+3+off), r12_im=10k+4+off,
// so every output word is known in advance from the frame offset alone.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_corr_frame_reader;

    localparam int DW   = 32;
    localparam int VL   = 4;
    localparam int NW   = 4 * VL;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] r11, r22, r12_re, r12_im;
    logic          din_valid, din_first, arm, continuous;
    logic [DW-1:0] dout;
    logic          dout_valid, dout_ready, dout_last, busy;
    logic [15:0]   frame_cnt, drop_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    corr_frame_reader #(.DIN_WIDTH(DW), .VECTOR_LEN(VL)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r11        (r11),
        .r22        (r22),
        .r12_re     (r12_re),
        .r12_im     (r12_im),
        .din_valid  (din_valid),
        .din_first  (din_first),
        .arm        (arm),
        .continuous (continuous),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int i, input int off);
        int b;
        b = 10 * (i / 4) + off;
        case (i % 4)
            0:       return DW'(b + 1);
            1:       return DW'(b + 2);
            2:       return DW'(-(b + 3));
            default: return DW'(b + 4);
        endcase
    endfunction

    task automatic send_sample(input int k, input int off, input bit first);
        r11       = DW'(10 * k + off + 1);
        r22       = DW'(10 * k + off + 2);
        r12_re    = DW'(-(10 * k + off + 3));
        r12_im    = DW'(10 * k + off + 4);
        din_valid = 1'b1;
        din_first = first;
        @(negedge clk);
        din_valid = 1'b0;
        din_first = 1'b0;
    endtask

    task automatic send_frame(input int off, input bit gapped);
        for (int k = 0; k < VL; k++) begin
            send_sample(k, off, k == 0);
            if (gapped && k < VL - 1) @(negedge clk);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Drains up to n_stop words, checking value, last flag and hold-while-stalled.
    task automatic collect(input int off, input bit rand_rdy, input bit chk_lat,
                           input int n_stop, input bit exp_busy, input int exp_frames);
        int         idx;
        int         cyc;
        int         wait_c;
        bit         seen;
        bit         rdy;
        bit         prev_stall;
        logic [33:0] held;
        idx = 0; cyc = 0; wait_c = 0; seen = 0; prev_stall = 0; held = '0;
        while (idx < n_stop && cyc < 400) begin
            if (!seen) begin
                if (dout_valid) seen = 1;
                else            wait_c++;
            end
            if (prev_stall) check("hold", {dout_valid, dout_last, dout}, held);
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            dout_ready = rdy;
            if (dout_valid && rdy) begin
                check($sformatf("word%0d", idx), dout, exp_word(idx, off));
                check($sformatf("last%0d", idx), dout_last, idx == NW - 1);
                idx++;
            end
            prev_stall = dout_valid && !rdy;
            held = {dout_valid, dout_last, dout};
            @(negedge clk);
            cyc++;
        end
        check("xfers", idx, n_stop);
        if (chk_lat) check("latency_le3", wait_c <= 3, 1);
        if (n_stop == NW) begin
            check("valid_after_last", dout_valid, 0);
            check("busy_after_last", busy, exp_busy);
            check("frame_cnt", frame_cnt, exp_frames);
        end
        dout_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; continuous = 1'b0; dout_ready = 1'b0;
        din_valid = 1'b0; din_first = 1'b0;
        r11 = '0; r22 = '0; r12_re = '0; r12_im = '0;
        repeat (3) @(negedge clk);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout_last", dout_last, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic
        pulse_arm();
        check("armed_busy", busy, 1);
        send_frame(0, 0);
        collect(0, 0, 1, NW, 0, 1);

        // Backpressure
        pulse_arm();
        send_frame(0, 0);
        collect(0, 1, 1, NW, 0, 2);

        // Resync: partial frame of offset 500 abandoned at bin 2
        pulse_arm();
        send_sample(0, 500, 1);
        send_sample(1, 500, 0);
        send_frame(0, 0);
        collect(0, 0, 1, NW, 0, 3);
        check("resync_drop_cnt", drop_cnt, 0);

        // Gapped input
        pulse_arm();
        send_frame(0, 1);
        collect(0, 0, 1, NW, 0, 4);

        // Overrun: two frames start during a stalled readout
        continuous = 1'b1;
        @(negedge clk);
        check("cont_arms", busy, 1);
        send_frame(0, 0);
        send_frame(100, 0);
        send_frame(200, 0);
        check("overrun_drop_cnt", drop_cnt, 2);
        check("overrun_stalled_valid", dout_valid, 1);
        collect(0, 0, 0, NW, 1, 5);
        send_frame(300, 0);
        collect(300, 0, 1, NW, 1, 6);
        continuous = 1'b0;
        check("overrun_drop_kept", drop_cnt, 2);

        // Reset during readout after word 5 (block is still ARMED here)
        send_frame(0, 0);
        collect(0, 0, 0, 5, 1, 0);
        rst_n = 1'b0;
        #3;
        check("midrst_dout_valid", dout_valid, 0);
        check("midrst_dout_last", dout_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dout", dout, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_drop_cnt", drop_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_arm();
        check("post_rst_armed", busy, 1);
        send_frame(200, 0);
        collect(200, 0, 1, NW, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
